// File: rtl/bp_cache_dma_mem_responder.sv
// DMA responder for bsg_cache fill traffic: accepts one packet, then
// streams a read burst out of, or absorbs a write burst into, local storage.
module bp_cache_dma_mem_responder #(
  parameter int addr_width_p = 40,
  parameter int data_width_p = 64,
  parameter int burst_len_p  = 8,
  parameter int mem_els_p    = 1024,
  localparam int dma_pkt_width_lp = 1 + addr_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [dma_pkt_width_lp-1:0] dma_pkt_i,
  input  logic                        dma_pkt_v_i,
  output logic                        dma_pkt_yumi_o,
  output logic [data_width_p-1:0]     dma_data_o,
  output logic                        dma_data_v_o,
  input  logic                        dma_data_ready_and_i,
  input  logic [data_width_p-1:0]     dma_data_i,
  input  logic                        dma_data_v_i,
  output logic                        dma_data_yumi_o
);

  localparam int idx_w_lp =
    (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam int off_w_lp = $clog2(data_width_p / 8);
  localparam int cnt_w_lp =
    (burst_len_p > 1) ? $clog2(burst_len_p) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam logic [cnt_w_lp-1:0] last_cnt_lp =
    cnt_w_lp'(burst_len_p - 1);

  logic [1:0]              state_q, state_d;
  logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
  logic [addr_width_p-1:0] addr_q, addr_d;

  logic [data_width_p-1:0] mem_q [mem_els_p];

  logic [idx_w_lp-1:0] base_idx;
  logic [idx_w_lp-1:0] mem_idx;
  logic                last_beat;
  logic                mem_we;
  logic                unused_addr;

  assign base_idx    = addr_q[off_w_lp +: idx_w_lp];
  // Index arithmetic is modulo storage size, so bursts wrap at the top.
  assign mem_idx     = base_idx + idx_w_lp'(cnt_q);
  assign last_beat   = (cnt_q == last_cnt_lp);
  assign unused_addr = ^addr_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    dma_pkt_yumi_o  = 1'b0;
    dma_data_v_o    = 1'b0;
    dma_data_o      = '0;
    dma_data_yumi_o = 1'b0;
    mem_we          = 1'b0;
    unique case (state_q)
      IDLE: begin
        dma_pkt_yumi_o = dma_pkt_v_i;
        if (dma_pkt_v_i) begin
          addr_d  = dma_pkt_i[addr_width_p-1:0];
          cnt_d   = '0;
          state_d = dma_pkt_i[addr_width_p]
                  ? WRITE : READ;
        end
      end
      READ: begin
        dma_data_v_o = 1'b1;
        dma_data_o   = mem_q[mem_idx];
        if (dma_data_ready_and_i) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + cnt_w_lp'(1);
          end
        end
      end
      WRITE: begin
        dma_data_yumi_o = dma_data_v_i;
        if (dma_data_v_i) begin
          mem_we = 1'b1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + cnt_w_lp'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Backing storage deliberately has no reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_idx] <= dma_data_i;
    end
  end

  a_pkt_stable: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    (dma_pkt_v_i && !dma_pkt_yumi_o) |=> $stable(dma_pkt_i)
  );

  a_ready_known: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    (state_q == READ) |-> !$isunknown(dma_data_ready_and_i)
  );

endmodule

// File: tb/tb_bp_cache_dma_mem_responder.sv
// Directed bench for bp_cache_dma_mem_responder with 16-word storage
// so that burst wrap-around is reachable.
module tb_bp_cache_dma_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [40:0] pkt;
  logic        pkt_v;
  logic        pkt_yumi;
  logic [63:0] data_o;
  logic        data_v_o;
  logic        ready;
  logic [63:0] data_i;
  logic        data_v_i;
  logic        data_yumi;

  int n_cmp = 0;
  int n_bad = 0;

  bp_cache_dma_mem_responder #(
    .addr_width_p(40),
    .data_width_p(64),
    .burst_len_p(8),
    .mem_els_p(16)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .dma_pkt_i(pkt),
    .dma_pkt_v_i(pkt_v),
    .dma_pkt_yumi_o(pkt_yumi),
    .dma_data_o(data_o),
    .dma_data_v_o(data_v_o),
    .dma_data_ready_and_i(ready),
    .dma_data_i(data_i),
    .dma_data_v_i(data_v_i),
    .dma_data_yumi_o(data_yumi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_pkt(input bit wr, input logic [39:0] a);
    @(negedge clk);
    pkt      = {wr, a};
    pkt_v    = 1'b1;
    data_v_i = 1'b0;
    #1;
    n_cmp++;
    if (pkt_yumi !== 1'b1) begin
      n_bad++;
      $display("FAIL pkt_accept addr=%h: yumi=%b want 1", a, pkt_yumi);
    end
  endtask

  task automatic write_beats(input logic [63:0] v [8], input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pkt_v    = 1'b0;
      data_v_i = 1'b1;
      data_i   = v[k];
      #1;
      n_cmp++;
      if (data_yumi !== 1'b1 || data_v_o !== 1'b0) begin
        n_bad++;
        $display("FAIL wr_beat%0d: yumi=%b v_o=%b want 1 0",
                 k, data_yumi, data_v_o);
      end
    end
    if (n == 8) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (data_yumi !== 1'b0) begin
        n_bad++;
        $display("FAIL wr_idle: yumi=%b want 0", data_yumi);
      end
      data_v_i = 1'b0;
    end
  endtask

  task automatic read_beats(input logic [63:0] e [8], input bit bp,
                            input bit busy);
    int beat = 0;
    int cyc  = 0;
    while (beat < 8 && cyc < 100) begin
      @(negedge clk);
      ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (busy) begin
        pkt      = {1'b0, 40'h70};
        pkt_v    = 1'b1;
        data_v_i = 1'b1;
        data_i   = 64'hDEAD_BEEF_0BAD_F00D;
      end else begin
        pkt_v    = 1'b0;
        data_v_i = 1'b0;
      end
      #1;
      n_cmp++;
      if (data_v_o !== 1'b1 || data_o !== e[beat]) begin
        n_bad++;
        $display("FAIL rd_beat%0d cyc%0d: v=%b d=%h want 1 %h",
                 beat, cyc, data_v_o, data_o, e[beat]);
      end
      if (busy) begin
        n_cmp++;
        if (pkt_yumi !== 1'b0 || data_yumi !== 1'b0) begin
          n_bad++;
          $display("FAIL busy%0d: pkt_yumi=%b data_yumi=%b want 0 0",
                   beat, pkt_yumi, data_yumi);
        end
      end
      if (ready) beat++;
      cyc++;
    end
    if (beat < 8) begin
      n_bad++;
      $display("FAIL rd_timeout: beats=%0d want 8", beat);
    end
    @(negedge clk);
    ready = 1'b0;
    #1;
    n_cmp++;
    if (data_v_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_end: v=%b want 0", data_v_o);
    end
    if (busy) begin
      n_cmp++;
      if (pkt_yumi !== 1'b1 || data_yumi !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_accept: pkt_yumi=%b data_yumi=%b want 1 0",
                 pkt_yumi, data_yumi);
      end
    end
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    pkt      = '0;
    pkt_v    = 1'b0;
    ready    = 1'b0;
    data_i   = '0;
    data_v_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({pkt_yumi, data_v_o, data_yumi} !== 3'b000 || data_o !== '0) begin
      n_bad++;
      $display("FAIL reset: pkt_yumi=%b v=%b yumi=%b d=%h want 0",
               pkt_yumi, data_v_o, data_yumi, data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    logic [63:0] v [8];
    v = '{64'h11, 64'h12, 64'h13, 64'h14,
          64'h15, 64'h16, 64'h17, 64'h18};
    start_pkt(1'b1, 40'h0);
    write_beats(v, 8);
    start_pkt(1'b0, 40'h0);
    read_beats(v, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    logic [63:0] v [8];
    v = '{64'h11, 64'h12, 64'h13, 64'h14,
          64'h15, 64'h16, 64'h17, 64'h18};
    start_pkt(1'b0, 40'h0);
    read_beats(v, 1'b1, 1'b0);
  endtask

  task automatic test_wrap;
    logic [63:0] v [8];
    logic [63:0] e [8];
    v = '{64'hA1, 64'hA2, 64'hA3, 64'hA4,
          64'hA5, 64'hA6, 64'hA7, 64'hA8};
    e = '{64'hA3, 64'hA4, 64'hA5, 64'hA6,
          64'hA7, 64'hA8, 64'h17, 64'h18};
    start_pkt(1'b1, 40'h70);
    write_beats(v, 8);
    start_pkt(1'b0, 40'h0);
    read_beats(e, 1'b0, 1'b0);
  endtask

  task automatic test_busy_stray;
    logic [63:0] e [8];
    logic [63:0] w [8];
    e = '{64'hA3, 64'hA4, 64'hA5, 64'hA6,
          64'hA7, 64'hA8, 64'h17, 64'h18};
    w = '{64'hA1, 64'hA2, 64'hA3, 64'hA4,
          64'hA5, 64'hA6, 64'hA7, 64'hA8};
    start_pkt(1'b0, 40'h0);
    read_beats(e, 1'b0, 1'b1);
    read_beats(w, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_burst;
    logic [63:0] c [8];
    logic [63:0] x [8];
    logic [63:0] e [8];
    c = '{64'hC1, 64'hC2, 64'hC3, 64'hC4,
          64'hC5, 64'hC6, 64'hC7, 64'hC8};
    x = '{64'hE1, 64'hE2, 64'hE3, 64'hE4,
          64'hE5, 64'hE6, 64'hE7, 64'hE8};
    e = '{64'hE1, 64'hE2, 64'hE3, 64'hC4,
          64'hC5, 64'hC6, 64'hC7, 64'hC8};
    start_pkt(1'b1, 40'h40);
    write_beats(c, 8);
    start_pkt(1'b1, 40'h40);
    write_beats(x, 3);
    @(negedge clk);
    data_v_i = 1'b1;
    data_i   = 64'hE4;
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pkt_yumi, data_v_o, data_yumi} !== 3'b000 || data_o !== '0) begin
      n_bad++;
      $display("FAIL async_rst: pkt_yumi=%b v=%b yumi=%b d=%h want 0",
               pkt_yumi, data_v_o, data_yumi, data_o);
    end
    @(negedge clk);
    data_v_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_pkt(1'b0, 40'h40);
    read_beats(e, 1'b0, 1'b0);
  endtask

  task automatic test_subword;
    logic [63:0] e [8];
    e = '{64'hA5, 64'hA6, 64'hA7, 64'hA8,
          64'h17, 64'h18, 64'hE1, 64'hE2};
    start_pkt(1'b0, 40'h13);
    read_beats(e, 1'b0, 1'b0);
    start_pkt(1'b0, 40'h10);
    read_beats(e, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_wrap();
    test_busy_stray();
    test_reset_mid_burst();
    test_subword();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_cache_dma_mem_responder.md
Name: bp_cache_dma_mem_responder

Overview:
- Responder end of the bsg_cache DMA interface, servicing one DMA channel as issued by the wormhole-to-cache-DMA fanout.
- Accepts a DMA packet, then either streams a burst of read fill words back to the requester or absorbs a burst of write fill words into internal storage.
- Used as the simulation DRAM endpoint in tethered testbenches, with one instance per CCE channel.

Parameters:
- addr_width_p, 40: DMA packet address width (caddr width).
- data_width_p, 64: fill word width (l2_fill_width); a power of two, at least 8.
- burst_len_p, 8: fill words per DMA packet (l2 block size in fills); at least 1.
- mem_els_p, 1024: number of data_width_p words in backing storage; a power of two.
- dma_pkt_width_lp, derived: 1+addr_width_p, laid out as {write_not_read, addr}.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- dma_pkt_i  in  dma_pkt_width_lp  DMA request; MSB is write_not_read, the rest is the byte address.
- dma_pkt_v_i  in  1  request valid.
- dma_pkt_yumi_o  out  1  request consumed this cycle.
- dma_data_o  out  data_width_p  read fill word to requester.
- dma_data_v_o  out  1  read fill word valid.
- dma_data_ready_and_i  in  1  requester ready for read fill word.
- dma_data_i  in  data_width_p  write fill word from requester.
- dma_data_v_i  in  1  write fill word valid.
- dma_data_yumi_o  out  1  write fill word consumed this cycle.

Behaviour:
- Reset (reset_n_i=0, asynchronous):
  - state=IDLE; beat counter=0; latched addr=0.
  - dma_pkt_yumi_o=0, dma_data_v_o=0, dma_data_yumi_o=0, dma_data_o=0.
  - Storage contents are not reset.
- Word index: base_idx = addr[lg(mem_els_p)+lg(data_width_p/8)-1 : lg(data_width_p/8)].
  - Address bits below the fill word are ignored.
  - Beat k accesses (base_idx+k) mod mem_els_p, so the burst wraps at the top of storage.
- IDLE:
  - dma_pkt_yumi_o = dma_pkt_v_i (combinational).
  - On yumi, latch write_not_read and addr, clear the counter, and go to WRITE if write_not_read=1, else READ.
  - dma_data_v_o=0 and dma_data_yumi_o=0 in IDLE.
- READ:
  - dma_data_v_o=1 and dma_data_o=mem[base_idx+cnt], both combinational from the current counter.
  - On dma_data_v_o & dma_data_ready_and_i, cnt++.
  - The handshake at cnt==burst_len_p-1 returns to IDLE with cnt=0.
  - Valid stays high and data stays stable while ready=0.
- WRITE:
  - dma_data_yumi_o = dma_data_v_i.
  - On yumi, mem[base_idx+cnt] <= dma_data_i at the clock edge, then cnt++.
  - The last beat returns to IDLE.
  - dma_data_v_o=0.
- Latency and throughput:
  - Packet accept to first read word valid is one cycle.
  - One beat per cycle at full throughput.
  - IDLE costs one cycle between packets, so back-to-back packets see a minimum 1-cycle gap after the last beat.
- Busy:
  - dma_pkt_yumi_o=0 in READ and WRITE.
  - A pending packet is held by the requester, not dropped.
- Stray data: dma_data_v_i outside WRITE is not consumed and does not alter storage.
- Counter: width is `BSG_SAFE_CLOG2(burst_len_p)`. With burst_len_p=1, every beat is the last.
- Reset mid-burst: returns to IDLE immediately and abandons the remaining beats. Words already written persist.
- Assertions (sim only):
  - dma_pkt_i must be stable while dma_pkt_v_i=1 and not yumi'd.
  - dma_data_ready_and_i must not be X in READ.

Test Plan:
1. Write then read:
   - Write pkt addr 0x0 with data 0x11..0x18 (8 beats).
   - Then read pkt addr 0x0.
   - Required: dma_data_o sequence 0x11..0x18; yumi asserted on each write beat; returns to IDLE after beat 8.
2. Read backpressure:
   - Read pkt with ready toggling 1,0,0,1,...
   - Required: each word held stable while ready=0; exactly 8 handshakes; the word order is unchanged.
3. Wrap-around:
   - mem_els_p=16, data_width_p=64, write pkt addr 0x70 (base_idx 14).
   - Required: beats land at indices 14,15,0..5; a read from addr 0x0 returns beats 3..8 first.
4. Busy and stray:
   - Assert a second pkt and dma_data_v_i during a READ burst.
   - Required: pkt_yumi=0 and data_yumi=0 until IDLE; the second pkt is accepted the cycle after the last read beat; storage is unchanged.
5. Reset mid-burst:
   - Drop reset_n_i after write beat 3 of 8.
   - Required: all outputs 0 asynchronously; the first 3 words retained; the next pkt is accepted from IDLE with cnt=0.
6. Sub-word address:
   - Read pkt addr 0x13 (data_width_p=64).
   - Required: identical to addr 0x10, starting at index 2.
